// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory request/response and decode handshake bundle
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          ins_valid;
  logic [31:0]   ins;
  logic [31:0]   PCp4;
  logic          ins_ready;
  logic [CW-1:0] count;
  modport master (
    output imem_req, imem_addr, ins_valid, ins, PCp4, count,
    input  imem_gnt, imem_rvalid, imem_rdata, ins_ready
  );
  modport slave (
    input  imem_req, imem_addr, ins_valid, ins, PCp4, count,
    output imem_gnt, imem_rvalid, imem_rdata, ins_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: owns the PC, fetches words from instruction memory and queues them for decode
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          INT,
  input  logic [31:0]   entryPoint,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d, drop_q, drop_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW:0]   occ;
  logic [31:0]   ins_q  [DEPTH];
  logic [31:0]   pcp4_q [DEPTH];
  logic          flush, accept, resp, push, pop;
  assign flush         = INT | redirect;
  assign occ           = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign bus.imem_req  = rst_n & ~flush & (occ < (CW+1)'(DEPTH));
  assign bus.imem_addr = pc_q;
  assign bus.ins_valid = count_q != '0;
  assign bus.ins       = ins_q[rptr_q];
  assign bus.PCp4      = pcp4_q[rptr_q];
  assign bus.count     = count_q;
  assign accept        = bus.imem_req & bus.imem_gnt;
  assign resp          = bus.imem_rvalid & inflight_q;
  assign push          = resp & ~drop_q & ~flush;
  assign pop           = bus.ins_valid & bus.ins_ready & ~flush;
  // next PC, outstanding-fetch tracking and FIFO bookkeeping; INT beats redirect, both flush
  always_comb begin
    pc_d       = INT ? {entryPoint[31:2], 2'b00} :
                 redirect ? {redirect_pc[31:2], 2'b00} :
                 accept ? pc_q + 32'd4 : pc_q;
    req_pc_d   = accept ? pc_q : req_pc_q;
    inflight_d = accept | (inflight_q & ~bus.imem_rvalid);
    drop_d     = flush ? inflight_d : (resp ? 1'b0 : drop_q);
    wptr_d     = flush ? '0 : wptr_q + AW'(push);
    rptr_d     = flush ? '0 : rptr_q + AW'(pop);
    count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end
  // FIFO storage: returned word plus the address of the following instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i]  <= '0;
        pcp4_q[i] <= '0;
      end
    end else if (push) begin
      ins_q[wptr_q]  <= bus.imem_rdata;
      pcp4_q[wptr_q] <= req_pc_q + 32'd4;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random and directed stimulus against a queue-based model of the fetch stream
module tb_fetch_queue;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        INT, redirect;
  logic [31:0] entryPoint, redirect_pc;
  fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'd128)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .entryPoint(entryPoint),
    .redirect(redirect), .redirect_pc(redirect_pc), .bus(bus)
  );
  always #10 clk = ~clk;
  int          vecs = 0;
  int          errs = 0;
  logic [63:0] exp_q [$];
  logic [31:0] m_pc = 32'd128;
  logic [31:0] m_addr = '0;
  logic        m_pend = 1'b0;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [63:0] mon_e;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask
  // one clock of stimulus: drive at negedge, check at +1, model update at +3 (after monitor at +2)
  task automatic cycle(input logic g, input logic r, input logic it, input logic rd,
                       input logic [31:0] rpc, input logic [31:0] ep);
    logic fl, e_req;
    @(negedge clk);
    bus.imem_gnt    = g;
    bus.ins_ready   = r;
    INT             = it;
    redirect        = rd;
    redirect_pc     = rpc;
    entryPoint      = ep;
    bus.imem_rvalid = mem_pend;
    bus.imem_rdata  = mem_addr >> 2;
    #1;
    fl    = it | rd;
    e_req = !fl && (exp_q.size() + int'(m_pend)) < DEPTH;
    chk("imem_req", 64'(bus.imem_req), 64'(e_req));
    if (e_req) chk("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
    chk("count", 64'(bus.count), 64'(exp_q.size()));
    chk("ins_valid", 64'(bus.ins_valid), 64'(exp_q.size() != 0));
    mem_pend = bus.imem_req & g;
    mem_addr = bus.imem_addr;
    #2;
    if (fl) begin
      exp_q.delete();
      m_pc   = it ? {ep[31:2], 2'b00} : {rpc[31:2], 2'b00};
      m_pend = 1'b0;
    end else begin
      if (m_pend) exp_q.push_back({m_addr >> 2, m_addr + 32'd4});
      if (e_req && g) begin
        m_addr = m_pc;
        m_pc   = m_pc + 32'd4;
      end
      m_pend = e_req && g;
    end
  endtask
  task automatic reset_checks();
    chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
    chk("rst_ins_valid", 64'(bus.ins_valid), 64'd0);
    chk("rst_ins", 64'(bus.ins), 64'd0);
    chk("rst_PCp4", 64'(bus.PCp4), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    exp_q.delete();
    m_pc            = 32'd128;
    m_pend          = 1'b0;
    mem_pend        = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_gnt    = 1'b0;
    INT             = 1'b0;
    redirect        = 1'b0;
  endtask
  // scoreboard monitor: every accepted instruction must match the oldest expected entry
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.ins_valid && bus.ins_ready && !(INT || redirect)) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL pop: got ins %h PCp4 %h, required no entry", bus.ins, bus.PCp4);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop", {bus.ins, bus.PCp4}, mon_e);
      end
    end
  end
  initial begin
    int n;
    rst_n = 1'b0;
    INT = 1'b0; redirect = 1'b0; entryPoint = '0; redirect_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.ins_ready = 1'b0;
    #13;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) cycle(1, 1, 0, 0, 0, 0);
    repeat (10) cycle(1, 0, 0, 0, 0, 0);
    repeat (8) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 32'h1000, 0);
    n = 0;
    while (!(exp_q.size() == 3 && m_pend) && n < 20) begin
      cycle(1, 0, 0, 0, 0, 0);
      n++;
    end
    chk("t3_reach_count3_inflight", 64'(n < 20), 64'd1);
    cycle(1, 1, 0, 1, 32'h203, 0);
    repeat (8) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 32'h300, 32'h82);
    repeat (8) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 32'hFFFF_FFF4, 0);
    repeat (6) cycle(1, 1, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #2;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cycle(1, 1, 0, 0, 0, 0);
    repeat (3000) begin
      logic [31:0] t;
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, t, $urandom);
    end
    repeat (10) cycle(0, 1, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
